sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
// Shares the single 32-bit SDRAM controller port between NUM_CLIENTS read requesters and the ROM download stream.
// Download bytes (ioctl) are packed little-endian into 32-bit words and written. Game reads (CPU ROM, tile, sprite) are granted round-robin.
// Sits between the game core's ROM fetch units and the sdram controller in the top level.
// PARAMETERS
// NUM_CLIENTS  4   number of read requesters (1..8)
// ADDR_WIDTH   23  SDRAM word (32-bit) address width
// DATA_WIDTH   32  SDRAM word width
// PORTS
// clk            in   1                       system clock (48 MHz)
// reset_n        in   1                       asynchronous, active-low reset
// ioctl_download in   1                       download in progress; reads blocked while high
// ioctl_addr     in   25                      byte address of ioctl_data
// ioctl_data     in   8                       download byte
// ioctl_wr       in   1                       one-cycle strobe: ioctl_data valid
// client_req     in   NUM_CLIENTS             level request per client
// client_addr    in   NUM_CLIENTS*ADDR_WIDTH  word address, client i at [i*AW +: AW]
// client_ack     out  NUM_CLIENTS             one-cycle pulse: request accepted by SDRAM
// client_valid   out  NUM_CLIENTS             one-cycle pulse: client_data holds read word
// client_data    out  DATA_WIDTH              read data (shared, qualify with client_valid)
// wr_overrun     out  1                       sticky: word completed while previous write pending
// sdram_addr     out  ADDR_WIDTH              to controller
// sdram_din      out  DATA_WIDTH              write data to controller
// sdram_we       out  1                       1 = write request
// sdram_req      out  1                       request, held until sdram_ack
// sdram_ack      in   1                       controller accepted request (one-cycle pulse)
// sdram_ready    in   1                       controller initialised and idle
// sdram_valid    in   1                       read data valid on sdram_dout (one-cycle pulse)
// sdram_dout     in   DATA_WIDTH              read data from controller
// BEHAVIOUR
// - Reset (reset_n=0, async): all outputs 0, FSM=IDLE, rr pointer=0, pack buffer and pending flag cleared.
// - Packing: on ioctl_wr, byte written into lane ioctl_addr[1:0] (lane0=[7:0]); when lane 3 written, word moves to
//   write register with address ioctl_addr[24:2]; pending=1 and lane buffer cleared to 0.
// - Falling edge of ioctl_download with lanes partially filled: flush as a word, unwritten lanes 0.
// - Word completes while pending=1: word dropped, wr_overrun<=1 (cleared only by reset).
// - FSM IDLE: if sdram_ready and pending -> register sdram_req=1, sdram_we=1, addr/din from write reg, -> WAIT_ACK.
//   else if sdram_ready, !ioctl_download, |client_req -> grant first requesting client at or after rr pointer,
//   register sdram_req=1, sdram_we=0, sdram_addr=client_addr[g], -> WAIT_ACK. Pending write beats any read.
// - sdram_req/addr/we appear the cycle after the IDLE decision; all outputs are registered.
// - WAIT_ACK: hold req/addr/we/din stable; on sdram_ack: sdram_req<=0; read -> client_ack[g] pulse, rr<=g+1 mod N,
//   -> WAIT_VALID; write -> pending<=0, -> IDLE (no client pulses).
// - WAIT_VALID: on sdram_valid: client_data<=sdram_dout, client_valid[g] pulse next cycle, -> IDLE.
// - Minimum read latency: client_req -> sdram_req 1 cycle; sdram_valid -> client_valid 1 cycle.
// - Client drops client_req after grant: transaction still completes, ack/valid still pulse to that client.
// - ioctl_download rising during a read: read completes normally; no further reads granted until it falls.
// - sdram_ack and sdram_valid in the same cycle: ack processed, valid accepted (skip WAIT_VALID wait).
// - At most one client_ack bit and one client_valid bit high per cycle; none outside a grant.
// TESTING
// 1 reset: assert reset_n=0 mid-WAIT_ACK -> sdram_req, client_ack, client_valid, wr_overrun all 0 same cycle.
// 2 download: bytes 11,22,33,44 at 0x000100..103, ioctl_wr 8 cycles apart -> one write, addr 0x40, din 0x44332211.
// 3 partial flush: bytes AA,BB at 0x10,0x11 then ioctl_download falls -> write addr 0x4, din 0x0000BBAA.
// 4 round-robin: all 4 clients req continuously, model acks -> grants in order 0,1,2,3,0; none starved.
// 5 priority: pending write + client 2 req in IDLE -> write first, then client 2 read; reads blocked while downloading.
// 6 overrun: two full words within 2 cycles, ack held off -> first word written, wr_overrun=1, second dropped.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: packs ioctl download bytes into 32-bit SDRAM writes and round-robins
// client reads onto the single controller port; pending writes beat reads.
module sdram_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              ioctl_download,
    input  logic [24:0]                       ioctl_addr,
    input  logic [7:0]                        ioctl_data,
    input  logic                              ioctl_wr,
    input  logic [NUM_CLIENTS-1:0]            client_req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
    output logic [NUM_CLIENTS-1:0]            client_ack,
    output logic [NUM_CLIENTS-1:0]            client_valid,
    output logic [DATA_WIDTH-1:0]             client_data,
    output logic                              wr_overrun,
    output logic [ADDR_WIDTH-1:0]             sdram_addr,
    output logic [DATA_WIDTH-1:0]             sdram_din,
    output logic                              sdram_we,
    output logic                              sdram_req,
    input  logic                              sdram_ack,
    input  logic                              sdram_ready,
    input  logic                              sdram_valid,
    input  logic [DATA_WIDTH-1:0]             sdram_dout
);
    localparam int GW = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_VALID} state_t;

    state_t                state, state_n;
    logic [31:0]           pack_buf, nbuf;
    logic [3:0]            pack_mask, nmask;
    logic [22:0]           pack_addr, word_addr;
    logic                  dl_q, dl_fall, word_done;
    logic                  pending, is_wr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [GW-1:0]         rr, g, gnt;
    logic                  gnt_hit, start_wr, start_rd;

    always_comb begin
        nbuf  = pack_buf;
        nmask = pack_mask;
        if (ioctl_wr) begin
            nbuf[{ioctl_addr[1:0], 3'b000} +: 8] = ioctl_data;
            nmask[ioctl_addr[1:0]]               = 1'b1;
        end
    end

    // a falling download edge flushes any partially filled word
    assign dl_fall   = dl_q & ~ioctl_download;
    assign word_done = (ioctl_wr && ioctl_addr[1:0] == 2'd3) || (dl_fall && |nmask);
    assign word_addr = ioctl_wr ? ioctl_addr[24:2] : pack_addr;

    // descending scan so the lowest offset from rr wins
    always_comb begin
        gnt     = '0;
        gnt_hit = 1'b0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (client_req[(int'(rr) + i) % NUM_CLIENTS]) begin
                gnt     = GW'((int'(rr) + i) % NUM_CLIENTS);
                gnt_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        start_wr = 1'b0;
        start_rd = 1'b0;
        case (state)
            IDLE: begin
                start_wr = sdram_ready && pending;
                start_rd = sdram_ready && !pending && !ioctl_download && gnt_hit;
                if (start_wr || start_rd) state_n = WAIT_ACK;
            end
            WAIT_ACK:   if (sdram_ack) state_n = (is_wr || sdram_valid) ? IDLE : WAIT_VALID;
            WAIT_VALID: if (sdram_valid) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack_buf     <= '0;
            pack_mask    <= '0;
            pack_addr    <= '0;
            dl_q         <= 1'b0;
            pending      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_overrun   <= 1'b0;
            is_wr        <= 1'b0;
            rr           <= '0;
            g            <= '0;
            sdram_req    <= 1'b0;
            sdram_we     <= 1'b0;
            sdram_addr   <= '0;
            sdram_din    <= '0;
            client_ack   <= '0;
            client_valid <= '0;
            client_data  <= '0;
        end else begin
            dl_q         <= ioctl_download;
            client_ack   <= '0;
            client_valid <= '0;
            pack_buf     <= word_done ? '0 : nbuf;
            pack_mask    <= word_done ? '0 : nmask;
            if (ioctl_wr) pack_addr <= ioctl_addr[24:2];
            if (word_done && pending) wr_overrun <= 1'b1;
            if (word_done && !pending) begin
                pending <= 1'b1;
                wr_addr <= ADDR_WIDTH'(word_addr);
                wr_data <= DATA_WIDTH'(nbuf);
            end
            if (start_wr) begin
                sdram_req  <= 1'b1;
                sdram_we   <= 1'b1;
                sdram_addr <= wr_addr;
                sdram_din  <= wr_data;
                is_wr      <= 1'b1;
            end
            if (start_rd) begin
                sdram_req  <= 1'b1;
                sdram_we   <= 1'b0;
                sdram_addr <= client_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
                is_wr      <= 1'b0;
                g          <= gnt;
            end
            if (state == WAIT_ACK && sdram_ack) begin
                sdram_req <= 1'b0;
                if (is_wr) pending <= 1'b0;
                else begin
                    client_ack[g] <= 1'b1;
                    rr            <= (int'(g) == NUM_CLIENTS - 1) ? '0 : g + 1'b1;
                    if (sdram_valid) begin
                        client_data     <= sdram_dout;
                        client_valid[g] <= 1'b1;
                    end
                end
            end
            if (state == WAIT_VALID && sdram_valid) begin
                client_data     <= sdram_dout;
                client_valid[g] <= 1'b1;
            end
        end
    end
endmodule
